// File: rtl/regfile_readback_checker.sv
// regfile_readback_checker
//
// Sweeps register file addresses FIRST_REG..LAST_REG two at a time and
// compares each read value against the address multiplied by MULT (truncated
// to 32 bits). It reports the number of mismatches and whether the sweep
// passed. It can also report the first register that failed.
//
// Ports
//   Clk            sole clock, rising edge
//   Rst            asynchronous active-low reset
//   Start          one-cycle sweep request, ignored while Busy
//   ReadRegister1  register file read address, port 1 (registered)
//   ReadRegister2  register file read address, port 2 (registered)
//   ReadData1      register file read data, port 1 (combinational from address)
//   ReadData2      register file read data, port 2
//   Busy           high in ISSUE and CHECK
//   Done           sweep complete, sticky until the next accepted Start
//   Pass           valid while Done, 1 = no mismatches
//   ErrorCount     mismatch count, saturates at 63
//   FirstFailReg   address of the first mismatching register
//   FirstFailData  data read from that register
//
// Build option
//   CHECKER_FAIL_LOG_EN  defined: FirstFailReg/FirstFailData capture the
//                        first mismatch of each sweep.
//                        undefined: both outputs are tied to 0 and no
//                        capture registers are built.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for Start after reset
// ISSUE | drive read addresses for pointer i and i+1
// CHECK | compare returned data and advance i by 2
// DONE  | results held, Done high, waiting for a new Start

module regfile_readback_checker #(
   parameter int FIRST_REG = 8,
   parameter int LAST_REG  = 25,
   parameter int MULT      = 3
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   output logic [4:0]  ReadRegister1,
   output logic [4:0]  ReadRegister2,
   input  logic [31:0] ReadData1,
   input  logic [31:0] ReadData2,
   output logic        Busy,
   output logic        Done,
   output logic        Pass,
   output logic [5:0]  ErrorCount,
   output logic [4:0]  FirstFailReg,
   output logic [31:0] FirstFailData
);

   // The pointer is 6 bits wide so that i+2 past register 31 cannot wrap.
   localparam logic [5:0]  FIRST_PTR = 6'(FIRST_REG);
   localparam logic [5:0]  LAST_PTR  = 6'(LAST_REG);
   localparam logic [31:0] MULT_W    = 32'(MULT);

   typedef enum logic [1:0] {IDLE, ISSUE, CHECK, DONE} state_t;

   state_t      state;
   logic [5:0]  ptr;
   logic [5:0]  ptrPlus1;
   logic [5:0]  ptrPlus2;
   logic [31:0] expect1;
   logic [31:0] expect2;
   logic        miss1;
   logic        miss2;
   logic [6:0]  errSum;
   logic [5:0]  newCount;
   logic        startAccept;

   always_comb begin
      ptrPlus1    = ptr + 6'd1;
      ptrPlus2    = ptr + 6'd2;
      expect1     = 32'(ptr) * MULT_W;
      expect2     = 32'(ptrPlus1) * MULT_W;
      miss1       = (ReadData1 != expect1);
      // Port 2 is only meaningful when i+1 is still inside the range.
      miss2       = (ptrPlus1 <= LAST_PTR) && (ReadData2 != expect2);
      errSum      = {1'b0, ErrorCount} + 7'(miss1) + 7'(miss2);
      newCount    = (errSum > 7'd63) ? 6'd63 : errSum[5:0];
      startAccept = Start && ((state == IDLE) || (state == DONE));
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state         <= IDLE;
         ptr           <= 6'd0;
         ReadRegister1 <= 5'd0;
         ReadRegister2 <= 5'd0;
         Busy          <= 1'b0;
         Done          <= 1'b0;
         Pass          <= 1'b0;
         ErrorCount    <= 6'd0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (startAccept) begin
                  state      <= ISSUE;
                  ptr        <= FIRST_PTR;
                  Busy       <= 1'b1;
                  Done       <= 1'b0;
                  Pass       <= 1'b0;
                  ErrorCount <= 6'd0;
               end
            end
            ISSUE: begin
               ReadRegister1 <= ptr[4:0];
               // An odd-length range ends on a single register, so port 2 repeats it.
               ReadRegister2 <= (ptr == LAST_PTR) ? ptr[4:0] : ptrPlus1[4:0];
               state         <= CHECK;
            end
            CHECK: begin
               ErrorCount <= newCount;
               ptr        <= ptrPlus2;
               if (ptrPlus2 > LAST_PTR) begin
                  state <= DONE;
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
                  Pass  <= (newCount == 6'd0);
               end else begin
                  state <= ISSUE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CHECKER_FAIL_LOG_EN
   // ErrorCount saturates and never returns to 0 within a sweep, so a zero
   // count means this is the first mismatch seen.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         FirstFailReg  <= 5'd0;
         FirstFailData <= 32'd0;
      end else if (startAccept) begin
         FirstFailReg  <= 5'd0;
         FirstFailData <= 32'd0;
      end else if ((state == CHECK) && (ErrorCount == 6'd0)) begin
         if (miss1) begin
            FirstFailReg  <= ptr[4:0];
            FirstFailData <= ReadData1;
         end else if (miss2) begin
            FirstFailReg  <= ptrPlus1[4:0];
            FirstFailData <= ReadData2;
         end
      end
   end
`else
   assign FirstFailReg  = 5'd0;
   assign FirstFailData = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_readback_checker.sv
module tb_regfile_readback_checker;

   typedef struct {
      logic [5:0]  err;
      logic        pass;
      logic [4:0]  fReg;
      logic [31:0] fData;
   } exp_t;

`ifdef CHECKER_FAIL_LOG_EN
   localparam bit LOG_EN = 1'b1;
`else
   localparam bit LOG_EN = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        StartA = 1'b0;
   logic        StartB = 1'b0;
   logic [31:0] rf [32];

   logic [4:0]  RR1A, RR2A, FFRegA, RR1B, RR2B, FFRegB;
   logic [31:0] RD1A, RD2A, FFDataA, RD1B, RD2B, FFDataB;
   logic        BusyA, DoneA, PassA, BusyB, DoneB, PassB;
   logic [5:0]  ErrA, ErrB;

   exp_t qA[$];
   exp_t qB[$];
   int   nChecks = 0;
   int   nPass = 0;

   always #5 Clk = ~Clk;

   assign RD1A = rf[RR1A];
   assign RD2A = rf[RR2A];
   assign RD1B = rf[RR1B];
   assign RD2B = rf[RR2B];

   regfile_readback_checker dutA (
      .Clk(Clk), .Rst(Rst), .Start(StartA),
      .ReadRegister1(RR1A), .ReadRegister2(RR2A),
      .ReadData1(RD1A), .ReadData2(RD2A),
      .Busy(BusyA), .Done(DoneA), .Pass(PassA), .ErrorCount(ErrA),
      .FirstFailReg(FFRegA), .FirstFailData(FFDataA)
   );

   regfile_readback_checker #(.FIRST_REG(8), .LAST_REG(24), .MULT(3)) dutB (
      .Clk(Clk), .Rst(Rst), .Start(StartB),
      .ReadRegister1(RR1B), .ReadRegister2(RR2B),
      .ReadData1(RD1B), .ReadData2(RD2B),
      .Busy(BusyB), .Done(DoneB), .Pass(PassB), .ErrorCount(ErrB),
      .FirstFailReg(FFRegB), .FirstFailData(FFDataB)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      nChecks++;
      if (act === expv) nPass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, expv);
   endtask

   function automatic exp_t mk(input logic [5:0] e, input logic p, input logic [4:0] r, input logic [31:0] d);
      exp_t x;
      x.err = e;
      x.pass = p;
      x.fReg = LOG_EN ? r : 5'd0;
      x.fData = LOG_EN ? d : 32'd0;
      return x;
   endfunction

   task automatic preload();
      for (int r = 0; r < 32; r++) rf[r] = 32'(r * 3);
   endtask

   task automatic pulse(input bit useB);
      @(negedge Clk);
      if (useB) StartB = 1'b1; else StartA = 1'b1;
      @(negedge Clk);
      StartA = 1'b0;
      StartB = 1'b0;
   endtask

   task automatic waitDone(input bit useB);
      int n = 0;
      while (!(useB ? DoneB : DoneA) && n < 40) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 40) check(useB ? "B done timeout" : "A done timeout", 0, 1);
      @(negedge Clk);
   endtask

   // Scoreboard monitor for dutA: busy cycles are counted between Done edges.
   initial begin
      int   busyCnt = 0;
      logic donePrev = 1'b0;
      exp_t e;
      forever begin
         @(negedge Clk);
         if (!Rst) busyCnt = 0;
         else begin
            if (BusyA) busyCnt++;
            if (DoneA && !donePrev) begin
               if (qA.size() == 0) check("A unexpected Done", 1, 0);
               else begin
                  e = qA.pop_front();
                  check("A busy cycles", 32'(busyCnt), 32'd18);
                  check("A ErrorCount", 32'(ErrA), 32'(e.err));
                  check("A Pass", 32'(PassA), 32'(e.pass));
                  check("A FirstFailReg", 32'(FFRegA), 32'(e.fReg));
                  check("A FirstFailData", FFDataA, e.fData);
               end
               busyCnt = 0;
            end
         end
         donePrev = DoneA;
      end
   end

   initial begin
      int   busyCnt = 0;
      logic donePrev = 1'b0;
      exp_t e;
      forever begin
         @(negedge Clk);
         if (!Rst) busyCnt = 0;
         else begin
            if (BusyB) busyCnt++;
            if (DoneB && !donePrev) begin
               if (qB.size() == 0) check("B unexpected Done", 1, 0);
               else begin
                  e = qB.pop_front();
                  check("B busy cycles", 32'(busyCnt), 32'd18);
                  check("B ErrorCount", 32'(ErrB), 32'(e.err));
                  check("B Pass", 32'(PassB), 32'(e.pass));
                  check("B FirstFailReg", 32'(FFRegB), 32'(e.fReg));
                  check("B FirstFailData", FFDataB, e.fData);
               end
               busyCnt = 0;
            end
         end
         donePrev = DoneB;
      end
   end

   initial begin
      preload();
      repeat (2) @(negedge Clk);
      check("reset Busy", 32'(BusyA), 0);
      check("reset Done", 32'(DoneA), 0);
      check("reset Pass", 32'(PassA), 0);
      check("reset ErrorCount", 32'(ErrA), 0);
      check("reset RR1", 32'(RR1A), 0);
      check("reset RR2", 32'(RR2A), 0);
      check("reset FirstFailReg", 32'(FFRegA), 0);
      check("reset FirstFailData", FFDataA, 0);
      Rst = 1'b1;

      // Clean sweep
      qA.push_back(mk(6'd0, 1'b1, 5'd0, 32'd0));
      pulse(1'b0);
      waitDone(1'b0);
      check("A RR1 hold", 32'(RR1A), 24);
      check("A RR2 hold", 32'(RR2A), 25);
      repeat (3) @(negedge Clk);
      check("A Done sticky", 32'(DoneA), 1);

      // Single corrupted register
      rf[13] = 32'd0;
      qA.push_back(mk(6'd1, 1'b0, 5'd13, 32'd0));
      pulse(1'b0);
      waitDone(1'b0);
      preload();

      // Both ports of one pair fail, plus one more later
      rf[10] = 32'hFFFF_FFFF;
      rf[11] = 32'hFFFF_FFFF;
      rf[21] = 32'd0;
      qA.push_back(mk(6'd3, 1'b0, 5'd10, 32'hFFFF_FFFF));
      pulse(1'b0);
      waitDone(1'b0);
      preload();

      // Start during a sweep is ignored
      qA.push_back(mk(6'd0, 1'b1, 5'd0, 32'd0));
      pulse(1'b0);
      repeat (3) @(negedge Clk);
      pulse(1'b0);
      waitDone(1'b0);

      // Reset mid-sweep clears everything at once and produces no Done
      rf[8] = 32'd0;
      pulse(1'b0);
      repeat (6) @(negedge Clk);
      check("pre-abort ErrorCount", 32'(ErrA), 1);
      Rst = 1'b0;
      #1;
      check("abort Busy", 32'(BusyA), 0);
      check("abort Done", 32'(DoneA), 0);
      check("abort ErrorCount", 32'(ErrA), 0);
      check("abort RR1", 32'(RR1A), 0);
      check("abort RR2", 32'(RR2A), 0);
      check("abort FirstFailReg", 32'(FFRegA), 0);
      check("abort FirstFailData", FFDataA, 0);
      @(negedge Clk);
      Rst = 1'b1;
      repeat (25) @(negedge Clk);
      check("no Done after abort", 32'(DoneA), 0);
      preload();

      // Start in the first edge after reset release runs a full sweep
      Rst = 1'b0;
      @(negedge Clk);
      rf[21] = 32'd0;
      qA.push_back(mk(6'd1, 1'b0, 5'd21, 32'd0));
      Rst = 1'b1;
      StartA = 1'b1;
      @(negedge Clk);
      StartA = 1'b0;
      waitDone(1'b0);
      preload();

      // Odd-length range: final pair is 24/24, port 2 unchecked
      qB.push_back(mk(6'd0, 1'b1, 5'd0, 32'd0));
      pulse(1'b1);
      waitDone(1'b1);
      check("B RR1 hold", 32'(RR1B), 24);
      check("B RR2 hold", 32'(RR2B), 24);
      rf[24] = 32'd0;
      qB.push_back(mk(6'd1, 1'b0, 5'd24, 32'd0));
      pulse(1'b1);
      waitDone(1'b1);
      preload();

      repeat (2) @(negedge Clk);
      check("A queue drained", 32'(qA.size()), 0);
      check("B queue drained", 32'(qB.size()), 0);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
